icetap_capture_buf: RTL and testbench

Single-clock trigger-aware capture buffer for the icetap logic analyser. Samples stream into a circular memory while armed. A trigger condition freezes the capture window at a programmable post-trigger depth. The stored window is then streamed out oldest-first over a valid/ready interface to the host-side readout logic.

---
 rtl/icetap_capture_buf.sv | 131 +++++++++++++
 tb/tb_icetap_capture_buf.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icetap_capture_buf.sv
// Trigger-aware circular capture buffer: stores samples while armed, freezes a
// DEPTH-sample window around an accepted trigger, then streams it oldest-first.
module icetap_capture_buf #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  trigger,
    output logic                  armed,
    output logic                  triggered,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_V  = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_READOUT
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // One pointer serves both phases: after capture it already names the oldest sample.
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] post_q;
    logic [ADDR_WIDTH-1:0] post_cnt;
    logic [ADDR_WIDTH:0]   fill;
    logic [ADDR_WIDTH:0]   issue_cnt;

    logic wr_en, trig_hit, post_done, last_xfer, issue;

    always_comb begin
        wr_en     = ((state == S_ARMED) || (state == S_POST)) && sample_valid;
        // DEPTH-1-post equals the bitwise complement of post in ADDR_WIDTH bits.
        trig_hit  = (state == S_ARMED) && sample_valid && trigger && (fill >= {1'b0, ~post_q});
        post_done = (state == S_POST) && sample_valid && (post_cnt == post_q - ADDR_WIDTH'(1));
        last_xfer = (state == S_READOUT) && rd_valid && rd_ready && rd_last;
        issue     = (state == S_READOUT) && (!rd_valid || rd_ready) && (issue_cnt != DEPTH_V)
                    && !last_xfer;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_ARMED;
            S_ARMED:   if (trig_hit) state_nxt = (post_q == '0) ? S_READOUT : S_POST;
            S_POST:    if (post_done) state_nxt = S_READOUT;
            S_READOUT: if (last_xfer) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        armed     = (state == S_ARMED) || (state == S_POST);
        triggered = (state == S_POST) || (state == S_READOUT);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr] <= sample_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            post_q    <= '0;
            post_cnt  <= '0;
            fill      <= '0;
            issue_cnt <= '0;
            trig_addr <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr       <= '0;
                        fill      <= '0;
                        post_q    <= post_count;
                        post_cnt  <= '0;
                        issue_cnt <= '0;
                    end
                end
                S_ARMED, S_POST: begin
                    if (sample_valid) begin
                        ptr <= ptr + ADDR_WIDTH'(1);
                        if (fill != DEPTH_V) fill <= fill + (ADDR_WIDTH + 1)'(1);
                        if (trig_hit) trig_addr <= ptr;
                        if (state == S_POST) post_cnt <= post_cnt + ADDR_WIDTH'(1);
                    end
                end
                S_READOUT: begin
                    if (last_xfer) begin
                        rd_valid  <= 1'b0;
                        rd_last   <= 1'b0;
                        rd_data   <= '0;
                        trig_addr <= '0;
                    end else if (issue) begin
                        rd_data   <= mem[ptr];
                        rd_valid  <= 1'b1;
                        rd_last   <= (issue_cnt == LAST_V);
                        ptr       <= ptr + ADDR_WIDTH'(1);
                        issue_cnt <= issue_cnt + (ADDR_WIDTH + 1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icetap_capture_buf.sv
// Bench for icetap_capture_buf: scenario and random captures checked against a
// queue-based model holding every stored sample since arming.
module tb_icetap_capture_buf;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, start, sample_valid, trigger, rd_ready;
    logic [AW-1:0] post_count;
    logic [DW-1:0] sample_data;
    logic          armed, triggered, rd_valid, rd_last;
    logic [AW-1:0] trig_addr;
    logic [DW-1:0] rd_data;

    icetap_capture_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .post_count   (post_count),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .trigger      (trigger),
        .armed        (armed),
        .triggered    (triggered),
        .trig_addr    (trig_addr),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: every valid sample since arming, index of accepted trigger, post samples seen
    logic [DW-1:0] mq[$];
    int            m_k;
    bit            m_trig;
    int            m_post;

    // readout capture
    logic [DW-1:0] gd[$];
    bit            gl[$];
    int            stall_bad;
    int            first_lat;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; start = 1'b0; sample_valid = 1'b0; trigger = 1'b0; rd_ready = 1'b0;
        tick;
        reset = 1'b0;
    endtask

    // start coincides with a valid triggering sample, which must be neither stored nor accepted
    task automatic arm(input int post);
        post_count   = AW'(post);
        start        = 1'b1;
        sample_valid = 1'b1;
        trigger      = 1'b1;
        sample_data  = 8'hEE;
        tick;
        start = 1'b0; trigger = 1'b0; sample_valid = 1'b0;
        mq.delete();
        m_trig = 1'b0;
        m_post = 0;
        m_k    = -1;
    endtask

    task automatic feed(input int post, input int trig_a, input int trig_b, input int vper,
                        input bit rnd, input int stop_post, input bit poke_start, output bit done);
        int idx;
        bit v, t;
        idx  = 0;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            v = (c % vper) == 0;
            if (rnd) begin
                sample_data = DW'($urandom);
                t = ($urandom_range(0, 7) == 0);
            end else begin
                sample_data = idx[DW-1:0];
                t = v && (idx == trig_a || idx == trig_b);
            end
            sample_valid = v;
            trigger      = t;
            start        = poke_start && (c == 3);
            tick;
            if (v) begin
                if (!m_trig && t && mq.size() >= DEPTH - 1 - post) begin
                    m_trig = 1'b1;
                    m_k    = mq.size();
                end else if (m_trig) begin
                    m_post++;
                end
                mq.push_back(sample_data);
                idx++;
                if (m_trig && (m_post == post || m_post == stop_post)) done = 1'b1;
            end
        end
        sample_valid = 1'b0; trigger = 1'b0; start = 1'b0;
    endtask

    // mode 0: always ready, 1: toggling 1,0,1,0, 2: random
    task automatic collect(input int mode);
        logic [DW-1:0] hd;
        bit hl, held, r;
        gd.delete(); gl.delete();
        stall_bad = 0; first_lat = -1; held = 1'b0; hd = '0; hl = 1'b0;
        for (int c = 0; c < 400 && gd.size() < DEPTH; c++) begin
            if (held && !(rd_valid === 1'b1 && rd_data === hd && rd_last === hl)) stall_bad++;
            if (first_lat < 0 && rd_valid === 1'b1) first_lat = c;
            case (mode)
                0:       r = 1'b1;
                1:       r = (c % 2) == 0;
                default: r = ($urandom_range(0, 1) == 1);
            endcase
            rd_ready = r;
            held = (rd_valid === 1'b1) && !r;
            hd = rd_data;
            hl = rd_last;
            if (rd_valid === 1'b1 && r) begin
                gd.push_back(rd_data);
                gl.push_back(rd_last);
            end
            tick;
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; sample_valid = 1'b0; trigger = 1'b0; rd_ready = 1'b0;
        post_count = '0; sample_data = '0;
        tick; tick;
        reset = 1'b0;
        n_cmp++;
        if ({armed, triggered, rd_valid, rd_last} !== 4'b0 || trig_addr !== '0 || rd_data !== '0) begin
            n_bad++;
            $display("FAIL reset_state got armed=%b trig=%b vld=%b last=%b ta=%0d rd=%0d want all 0",
                     armed, triggered, rd_valid, rd_last, trig_addr, rd_data);
        end
    endtask

    task automatic test_capture(input string name, input int post, input int trig_a, input int trig_b,
                                input int vper, input bit rnd, input int mode, input bit poke);
        bit done;
        int bad_d, bad_l, base;
        arm(post);
        n_cmp++;
        if (armed !== 1'b1 || triggered !== 1'b0) begin
            n_bad++;
            $display("FAIL %s arm got armed=%b triggered=%b want 1 0", name, armed, triggered);
        end
        feed(post, trig_a, trig_b, vper, rnd, -1, poke, done);
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s capture got no trigger window want completed window", name);
            do_reset;
            return;
        end
        n_cmp++;
        if (armed !== 1'b0 || triggered !== 1'b1 || trig_addr !== AW'(m_k % DEPTH)) begin
            n_bad++;
            $display("FAIL %s trigger got armed=%b triggered=%b trig_addr=%0d want 0 1 %0d",
                     name, armed, triggered, trig_addr, m_k % DEPTH);
        end
        collect(mode);
        n_cmp++;
        if (gd.size() != DEPTH || first_lat < 0 || first_lat > 2) begin
            n_bad++;
            $display("FAIL %s readout got beats=%0d first_valid=%0d want %0d beats, first_valid<=2",
                     name, gd.size(), first_lat, DEPTH);
        end
        base  = mq.size() - DEPTH;
        bad_d = 0;
        bad_l = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i >= gd.size() || gd[i] !== mq[base + i]) bad_d++;
            if (i >= gl.size() || gl[i] !== (i == DEPTH - 1)) bad_l++;
        end
        n_cmp++;
        if (bad_d != 0) begin
            n_bad++;
            $display("FAIL %s rd_data got %0d wrong beats (beat0=%0d) want 0 wrong (beat0=%0d)",
                     name, bad_d, (gd.size() > 0) ? int'(gd[0]) : -1, mq[base]);
        end
        n_cmp++;
        if (bad_l != 0) begin
            n_bad++;
            $display("FAIL %s rd_last got %0d wrong beats want 0", name, bad_l);
        end
        n_cmp++;
        if (stall_bad != 0) begin
            n_bad++;
            $display("FAIL %s stall_hold got %0d unstable stalls want 0", name, stall_bad);
        end
        n_cmp++;
        if ({armed, triggered, rd_valid, rd_last} !== 4'b0 || trig_addr !== '0 || rd_data !== '0) begin
            n_bad++;
            $display("FAIL %s end_idle got armed=%b trig=%b vld=%b last=%b ta=%0d rd=%0d want all 0",
                     name, armed, triggered, rd_valid, rd_last, trig_addr, rd_data);
            do_reset;
        end
    endtask

    task automatic test_reset_mid_post;
        bit done;
        arm(4);
        feed(4, 20, -1, 1, 1'b0, 2, 1'b0, done);
        n_cmp++;
        if (!done || armed !== 1'b1 || triggered !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_post got done=%b armed=%b triggered=%b want 1 1 1", done, armed, triggered);
        end
        sample_valid = 1'b1;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        sample_valid = 1'b0;
        n_cmp++;
        if ({armed, triggered, rd_valid, rd_last} !== 4'b0 || trig_addr !== '0 || rd_data !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_post got armed=%b trig=%b vld=%b last=%b ta=%0d rd=%0d want all 0",
                     armed, triggered, rd_valid, rd_last, trig_addr, rd_data);
        end
    endtask

    initial begin
        test_reset;
        test_capture("s1_basic",      4, 20, -1, 1, 1'b0, 0, 1'b0);
        test_capture("s2_early_trig", 4,  5, 15, 1, 1'b0, 0, 1'b0);
        test_capture("s3_post0",      0, 30, -1, 1, 1'b0, 0, 1'b0);
        test_capture("s4_stall",      4, 20, -1, 1, 1'b0, 1, 1'b0);
        test_capture("s5_sparse",     2, 40, -1, 3, 1'b0, 0, 1'b0);
        test_reset_mid_post;
        test_capture("s6_rerun",      4, 20, -1, 1, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++)
            test_capture("random", $urandom_range(0, DEPTH - 1), -1, -1, $urandom_range(1, 3), 1'b1, 2, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
